// File: rtl/mc_dly_sample_pkg.sv
// Shared constants and helpers for the multi-channel delay sampler.
// MC_DLY_SAMPLE_CNT_EN (optional) adds per-channel saturating drop counters of OVF_CNT_W bits.
package mc_dly_sample_pkg;

  localparam int DW_DEF       = 32;
  localparam int NCH_DEF      = 4;
  localparam int SYNC_STG_MIN = 2;
  localparam int OVF_CNT_W    = 8;

  // Index width that never collapses to zero for a single channel.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dly_sync_edge.sv
// Multi-flop synchroniser for one asynchronous enable, followed by an edge detector.
// TOGGLE_MODE=0 pulses on rising edges only, TOGGLE_MODE=1 on either edge.
module dly_sync_edge #(
  parameter int SYNC_STG    = 2,
  parameter int TOGGLE_MODE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic edge_pls
);

  logic [SYNC_STG-1:0] sync_q;
  logic                edge_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], async_in};
      edge_q <= sync_q[SYNC_STG-1];
    end
  end

  assign sync_out = sync_q[SYNC_STG-1];

  if (TOGGLE_MODE != 0) begin : g_toggle
    assign edge_pls = sync_out ^ edge_q;
  end else begin : g_rise
    assign edge_pls = sync_out & ~edge_q;
  end

endmodule

// File: rtl/mc_dly_sample.sv
// NCH-channel delay sampler: per-channel synchronised capture merged onto one valid/ready stream
// by a round-robin arbiter. Define MC_DLY_SAMPLE_CNT_EN to add the ovf_cnt drop counters.
module mc_dly_sample
  import mc_dly_sample_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int NCH         = NCH_DEF,
  parameter int SYNC_STG    = SYNC_STG_MIN,
  parameter int TOGGLE_MODE = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NCH*DW-1:0]             din,
  input  logic [NCH-1:0]                din_en,
  output logic [NCH-1:0]                ack,
  output logic [DW-1:0]                 m_data,
  output logic [clog2_min1(NCH)-1:0]    m_ch,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [NCH-1:0]                ovf,
`ifdef MC_DLY_SAMPLE_CNT_EN
  output logic [NCH*OVF_CNT_W-1:0]      ovf_cnt,
`endif
  input  logic [NCH-1:0]                ovf_clr
);

  localparam int CW = clog2_min1(NCH);

  logic [NCH-1:0] edge_p;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] grant;
  logic [NCH-1:0] drop;
  logic [DW-1:0]  cap [NCH];
  logic [CW-1:0]  ptr;
  logic [CW-1:0]  gnt_idx;
  logic           gnt_vld;
  logic           slot_free;
  int             idx;

  assign slot_free = !m_valid || m_ready;

  // Walk down from the farthest candidate so the last hit is the first pending at/after ptr.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NCH;
      if (pend[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = CW'(idx);
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic          pend_q;
    logic          ovf_q;
    logic [DW-1:0] cap_q;

    dly_sync_edge #(
      .SYNC_STG    (SYNC_STG),
      .TOGGLE_MODE (TOGGLE_MODE)
    ) u_sync_edge (
      .clk      (clk),
      .rst      (rst),
      .async_in (din_en[i]),
      .sync_out (ack[i]),
      .edge_pls (edge_p[i])
    );

    assign grant[i] = slot_free && gnt_vld && (gnt_idx == CW'(i));
    // A new word is only lost if the old one is still waiting and not leaving this cycle.
    assign drop[i]  = edge_p[i] && pend_q && !grant[i];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pend_q <= 1'b0;
        ovf_q  <= 1'b0;
        cap_q  <= '0;
      end else begin
        if (edge_p[i] && !drop[i])
          cap_q <= din[i*DW +: DW];
        if (edge_p[i])
          pend_q <= 1'b1;
        else if (grant[i])
          pend_q <= 1'b0;
        if (drop[i])
          ovf_q <= 1'b1;
        else if (ovf_clr[i])
          ovf_q <= 1'b0;
      end
    end

    assign pend[i] = pend_q;
    assign ovf[i]  = ovf_q;
    assign cap[i]  = cap_q;

`ifdef MC_DLY_SAMPLE_CNT_EN
    logic [OVF_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        cnt_q <= '0;
      else if (drop[i])
        cnt_q <= ovf_clr[i] ? OVF_CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
      else if (ovf_clr[i])
        cnt_q <= '0;
    end

    assign ovf_cnt[i*OVF_CNT_W +: OVF_CNT_W] = cnt_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ch    <= '0;
      ptr     <= '0;
    end else if (slot_free) begin
      m_valid <= gnt_vld;
      if (gnt_vld) begin
        m_data <= cap[gnt_idx];
        m_ch   <= gnt_idx;
        ptr    <= (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mc_dly_sample.sv
// Directed bench for mc_dly_sample: main instance (NCH=4, rising edge) and a toggle-mode instance (NCH=2).
// The drop-counter test only runs when MC_DLY_SAMPLE_CNT_EN is defined.
module tb_mc_dly_sample;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4*DW-1:0] din;
  logic [3:0]      din_en;
  logic [3:0]      ack;
  logic [DW-1:0]   m_data;
  logic [1:0]      m_ch;
  logic            m_valid;
  logic            m_ready;
  logic [3:0]      ovf;
  logic [3:0]      ovf_clr;

  logic [2*DW-1:0] t_din;
  logic [1:0]      t_din_en;
  logic [1:0]      t_ack;
  logic [DW-1:0]   t_m_data;
  logic            t_m_ch;
  logic            t_m_valid;
  logic            t_m_ready;
  logic [1:0]      t_ovf;
  logic [1:0]      t_ovf_clr;

`ifdef MC_DLY_SAMPLE_CNT_EN
  logic [31:0]     ovf_cnt;
  logic [15:0]     t_ovf_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  mc_dly_sample #(.DW(DW), .NCH(4), .SYNC_STG(2), .TOGGLE_MODE(0)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .din_en  (din_en),
    .ack     (ack),
    .m_data  (m_data),
    .m_ch    (m_ch),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .ovf     (ovf),
`ifdef MC_DLY_SAMPLE_CNT_EN
    .ovf_cnt (ovf_cnt),
`endif
    .ovf_clr (ovf_clr)
  );

  mc_dly_sample #(.DW(DW), .NCH(2), .SYNC_STG(2), .TOGGLE_MODE(1)) u_tgl (
    .clk     (clk),
    .rst     (rst),
    .din     (t_din),
    .din_en  (t_din_en),
    .ack     (t_ack),
    .m_data  (t_m_data),
    .m_ch    (t_m_ch),
    .m_valid (t_m_valid),
    .m_ready (t_m_ready),
    .ovf     (t_ovf),
`ifdef MC_DLY_SAMPLE_CNT_EN
    .ovf_cnt (t_ovf_cnt),
`endif
    .ovf_clr (t_ovf_clr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic burst(input logic [4*DW-1:0] words);
    din    = words;
    din_en = 4'hF;
    cyc(3);
    check("rr_wait", 64'(m_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check("rr_valid", 64'(m_valid), 64'd1);
      check("rr_ch", 64'(m_ch), 64'(i));
      check("rr_data", 64'(m_data), 64'(words[i*DW +: DW]));
    end
    cyc(1);
    check("rr_idle", 64'(m_valid), 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    din       = '0;
    din_en    = '0;
    m_ready   = 1'b0;
    ovf_clr   = '0;
    t_din     = '0;
    t_din_en  = '0;
    t_m_ready = 1'b1;
    t_ovf_clr = '0;

    // Reset state
    cyc(3);
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_data", 64'(m_data), 64'd0);
    check("rst_ch", 64'(m_ch), 64'd0);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_t_valid", 64'(t_m_valid), 64'd0);
    rst = 1'b0;
    cyc(1);

    // Single event: ack at edge 2, word at edge 4, gone at edge 5
    din[0 +: DW] = 32'hDEADBEEF;
    din_en[0]    = 1'b1;
    m_ready      = 1'b1;
    cyc(1);
    check("t1_ack_e1", 64'(ack[0]), 64'd0);
    cyc(1);
    check("t1_ack_e2", 64'(ack[0]), 64'd1);
    cyc(1);
    check("t1_valid_e3", 64'(m_valid), 64'd0);
    cyc(1);
    check("t1_valid_e4", 64'(m_valid), 64'd1);
    check("t1_data_e4", 64'(m_data), 64'hDEADBEEF);
    check("t1_ch_e4", 64'(m_ch), 64'd0);
    cyc(1);
    check("t1_valid_e5", 64'(m_valid), 64'd0);

    // Falling edges capture nothing in rising-edge mode
    din_en = '0;
    cyc(4);
    check("fall_quiet", 64'(m_valid), 64'd0);
    cyc(2);

    // Mid-run reset clears the held output word and the pointer (it was 1)
    rst = 1'b1;
    cyc(1);
    check("midrst_data", 64'(m_data), 64'd0);
    check("midrst_valid", 64'(m_valid), 64'd0);
    rst = 1'b0;
    cyc(1);

    // Round robin, then a second burst starting again at ch0
    burst({32'h44, 32'h33, 32'h22, 32'h11});
    din_en = '0;
    cyc(5);
    burst({32'h88, 32'h77, 32'h66, 32'h55});

    // Backpressure and overrun on ch1 (slot pre-filled by ch0)
    m_ready          = 1'b0;
    din_en[1:0]      = 2'b00;
    din[0 +: DW]     = 32'hC0C0C0C0;
    din[DW +: DW]    = 32'hA1A1A1A1;
    cyc(4);
    din_en[1:0] = 2'b11;
    cyc(4);
    check("t3_slot_valid", 64'(m_valid), 64'd1);
    check("t3_slot_data", 64'(m_data), 64'hC0C0C0C0);
    check("t3_slot_ch", 64'(m_ch), 64'd0);
    cyc(3);
    check("t3_stall_data", 64'(m_data), 64'hC0C0C0C0);
    check("t3_stall_valid", 64'(m_valid), 64'd1);
    din_en[1] = 1'b0;
    cyc(4);
    din[DW +: DW] = 32'hA2A2A2A2;
    din_en[1]     = 1'b1;
    cyc(2);
    check("t3_ovf_pre", 64'(ovf), 64'd0);
    cyc(1);
    check("t3_ovf_set", 64'(ovf), 64'h2);
    m_ready = 1'b1;
    cyc(1);
    check("t3_a1_valid", 64'(m_valid), 64'd1);
    check("t3_a1_data", 64'(m_data), 64'hA1A1A1A1);
    check("t3_a1_ch", 64'(m_ch), 64'd1);
    cyc(1);
    check("t3_drained", 64'(m_valid), 64'd0);
    check("t3_ovf_sticky", 64'(ovf), 64'h2);
    ovf_clr[1] = 1'b1;
    cyc(1);
    ovf_clr = '0;
    check("t3_ovf_clr", 64'(ovf), 64'd0);

    // Grant collision on ch2: second edge lands on the cycle ch2 is granted
    m_ready     = 1'b0;
    din_en[3:2] = 2'b00;
    cyc(4);
    din[3*DW +: DW] = 32'hD3D3D3D3;
    din_en[3]       = 1'b1;
    cyc(4);
    check("t4_d3_data", 64'(m_data), 64'hD3D3D3D3);
    check("t4_d3_ch", 64'(m_ch), 64'd3);
    din[2*DW +: DW] = 32'hB1B1B1B1;
    din_en[2]       = 1'b1;
    cyc(3);
    din_en[2] = 1'b0;
    cyc(4);
    din[2*DW +: DW] = 32'hB2B2B2B2;
    din_en[2]       = 1'b1;
    cyc(2);
    m_ready = 1'b1;
    cyc(1);
    check("t4_b1_valid", 64'(m_valid), 64'd1);
    check("t4_b1_data", 64'(m_data), 64'hB1B1B1B1);
    check("t4_b1_ch", 64'(m_ch), 64'd2);
    check("t4_ovf_a", 64'(ovf), 64'd0);
    cyc(1);
    check("t4_b2_valid", 64'(m_valid), 64'd1);
    check("t4_b2_data", 64'(m_data), 64'hB2B2B2B2);
    check("t4_b2_ch", 64'(m_ch), 64'd2);
    cyc(1);
    check("t4_idle", 64'(m_valid), 64'd0);
    check("t4_ovf_b", 64'(ovf), 64'd0);

    // Toggle mode: 0->1 and 1->0 each capture
    t_din[0 +: DW] = 32'h5A5A0001;
    t_din_en[0]    = 1'b1;
    cyc(3);
    check("t5_rise_wait", 64'(t_m_valid), 64'd0);
    cyc(1);
    check("t5_rise_valid", 64'(t_m_valid), 64'd1);
    check("t5_rise_data", 64'(t_m_data), 64'h5A5A0001);
    check("t5_rise_ch", 64'(t_m_ch), 64'd0);
    cyc(1);
    check("t5_rise_idle", 64'(t_m_valid), 64'd0);
    cyc(1);
    t_din[0 +: DW] = 32'h5A5A0002;
    t_din_en[0]    = 1'b0;
    cyc(3);
    check("t5_fall_wait", 64'(t_m_valid), 64'd0);
    cyc(1);
    check("t5_fall_valid", 64'(t_m_valid), 64'd1);
    check("t5_fall_data", 64'(t_m_data), 64'h5A5A0002);
    cyc(1);
    check("t5_fall_idle", 64'(t_m_valid), 64'd0);

`ifdef MC_DLY_SAMPLE_CNT_EN
    // 302 rising edges with the sink stalled: one to the slot, one pending, 300 dropped
    m_ready   = 1'b0;
    din_en[0] = 1'b0;
    cyc(4);
    for (int i = 0; i < 302; i++) begin
      din_en[0] = 1'b1;
      cyc(4);
      din_en[0] = 1'b0;
      cyc(4);
    end
    check("t6_cnt_sat", 64'(ovf_cnt[7:0]), 64'd255);
    check("t6_cnt_other", 64'(ovf_cnt[15:8]), 64'd0);
    check("t6_ovf0", 64'(ovf[0]), 64'd1);
    ovf_clr[0] = 1'b1;
    cyc(1);
    ovf_clr = '0;
    check("t6_cnt_clr", 64'(ovf_cnt[7:0]), 64'd0);
    check("t6_ovf0_clr", 64'(ovf[0]), 64'd0);
    m_ready = 1'b1;
    cyc(4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
